// File: rtl/rf_pkg.sv
//======================================================================
// Module : rf_pkg
// Brief  : Shared widths and requester IDs for the register-file
//          writeback path.
// Rev    : 1.0
//======================================================================
`default_nettype none

package rf_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int DEPTH    = 2;

    typedef enum logic {
        RQ_ALU  = 1'b0,
        RQ_LOAD = 1'b1
    } rq_id_e;

endpackage

`default_nettype wire

// File: rtl/regfile_write_arbiter_wb_queue.sv
//======================================================================
// Module : wb_queue
// Brief  : DEPTH-entry {addr,data} FIFO for one writeback requester.
// Rev    : 1.0
//======================================================================
`default_nettype none

module wb_queue #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          i_push,
    input  logic [ADDR_W-1:0]             i_addr,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_pop,
    output logic [CNT_W-1:0]              o_count,
    output logic                          o_empty,
    output logic [ADDR_W-1:0]             o_head_addr,
    output logic [DATA_W-1:0]             o_head_data,
    output logic [DEPTH-1:0]              o_valid_mask,
    output logic [DEPTH-1:0][ADDR_W-1:0]  o_entry_addr
);

    logic [PTR_W-1:0]             r_rd;
    logic [PTR_W-1:0]             r_wr;
    logic [CNT_W-1:0]             r_count;
    logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
    logic [DEPTH-1:0][DATA_W-1:0] r_data;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_push & ~w_full;
    assign w_pop   = i_pop & ~w_empty;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr] <= i_addr;
            r_data[r_wr] <= i_data;
        end
    end

    always_comb begin
        o_valid_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_valid_mask[i] = ({1'b0, PTR_W'(i) - r_rd} < r_count);
        end
    end

    assign o_count      = r_count;
    assign o_empty      = w_empty;
    assign o_head_addr  = r_addr[r_rd];
    assign o_head_data  = r_data[r_rd];
    assign o_entry_addr = r_addr;

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
//======================================================================
// Module : regfile_write_arbiter
// Brief  : Round-robin merge of ALU and load writebacks onto the single
//          register-file write port, with a pending-write scoreboard.
// Rev    : 1.0
//======================================================================
`default_nettype none

module regfile_write_arbiter #(
    parameter int  DATA_W   = rf_pkg::DATA_W,
    parameter int  ADDR_W   = rf_pkg::ADDR_W,
    parameter int  DEPTH    = rf_pkg::DEPTH,
    localparam int NUM_REGS = 1 << ADDR_W
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                wb0_valid,
    input  logic [ADDR_W-1:0]   wb0_addr,
    input  logic [DATA_W-1:0]   wb0_data,
    output logic                wb0_ready,
    input  logic                wb1_valid,
    input  logic [ADDR_W-1:0]   wb1_addr,
    input  logic [DATA_W-1:0]   wb1_data,
    output logic                wb1_ready,
    output logic                Write_En,
    output logic [ADDR_W-1:0]   Write_Addr,
    output logic [DATA_W-1:0]   Write_Data,
    output logic [NUM_REGS-1:0] pending,
    output logic                grant_id
);

    import rf_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]             w_cnt0,  w_cnt1;
    logic                         w_empty0, w_empty1;
    logic [ADDR_W-1:0]            w_haddr0, w_haddr1;
    logic [DATA_W-1:0]            w_hdata0, w_hdata1;
    logic [DEPTH-1:0]             w_vmask0, w_vmask1;
    logic [DEPTH-1:0][ADDR_W-1:0] w_eaddr0, w_eaddr1;

    logic   w_push0, w_push1;
    logic   w_pop0,  w_pop1;
    logic   w_any;
    logic   w_both;
    rq_id_e w_gnt;

    rq_id_e            r_rr;
    rq_id_e            r_gnt;
    logic              r_wen;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [NUM_REGS-1:0] w_pending;

    // Ready is a function of occupancy only, so valid never loops back into it.
    assign wb0_ready = (w_cnt0 < CNT_W'(DEPTH));
    assign wb1_ready = (w_cnt1 < CNT_W'(DEPTH));
    assign w_push0   = wb0_valid & wb0_ready;
    assign w_push1   = wb1_valid & wb1_ready;

    wb_queue #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_q_alu (
        .clk          (clk),
        .clr          (clr),
        .i_push       (w_push0),
        .i_addr       (wb0_addr),
        .i_data       (wb0_data),
        .i_pop        (w_pop0),
        .o_count      (w_cnt0),
        .o_empty      (w_empty0),
        .o_head_addr  (w_haddr0),
        .o_head_data  (w_hdata0),
        .o_valid_mask (w_vmask0),
        .o_entry_addr (w_eaddr0)
    );

    wb_queue #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_q_load (
        .clk          (clk),
        .clr          (clr),
        .i_push       (w_push1),
        .i_addr       (wb1_addr),
        .i_data       (wb1_data),
        .i_pop        (w_pop1),
        .o_count      (w_cnt1),
        .o_empty      (w_empty1),
        .o_head_addr  (w_haddr1),
        .o_head_data  (w_hdata1),
        .o_valid_mask (w_vmask1),
        .o_entry_addr (w_eaddr1)
    );

    always_comb begin
        w_any  = ~w_empty0 | ~w_empty1;
        w_both = ~w_empty0 & ~w_empty1;
        if (w_empty0) begin
            w_gnt = RQ_LOAD;
        end else if (w_empty1) begin
            w_gnt = RQ_ALU;
        end else begin
            w_gnt = r_rr;
        end
        w_pop0 = w_any & (w_gnt == RQ_ALU);
        w_pop1 = w_any & (w_gnt == RQ_LOAD);
    end

    // The rr pointer only moves when both heads actually competed.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_rr    <= RQ_ALU;
            r_gnt   <= RQ_ALU;
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= w_any;
            if (w_any) begin
                r_gnt   <= w_gnt;
                r_waddr <= (w_gnt == RQ_LOAD) ? w_haddr1 : w_haddr0;
                r_wdata <= (w_gnt == RQ_LOAD) ? w_hdata1 : w_hdata0;
            end
            if (w_both) begin
                r_rr <= (w_gnt == RQ_ALU) ? RQ_LOAD : RQ_ALU;
            end
        end
    end

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_vmask0[i]) begin
                w_pending[w_eaddr0[i]] = 1'b1;
            end
            if (w_vmask1[i]) begin
                w_pending[w_eaddr1[i]] = 1'b1;
            end
        end
        if (r_wen) begin
            w_pending[r_waddr] = 1'b1;
        end
    end

    assign Write_En   = r_wen;
    assign Write_Addr = r_waddr;
    assign Write_Data = r_wdata;
    assign grant_id   = r_gnt;
    assign pending    = w_pending;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
//======================================================================
// Module : tb_regfile_write_arbiter
// Brief  : Directed self-checking bench for regfile_write_arbiter.
// Rev    : 1.0
//======================================================================
`default_nettype none

module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        wb0_valid = 1'b0;
    logic [2:0]  wb0_addr  = '0;
    logic [15:0] wb0_data  = '0;
    logic        wb0_ready;
    logic        wb1_valid = 1'b0;
    logic [2:0]  wb1_addr  = '0;
    logic [15:0] wb1_data  = '0;
    logic        wb1_ready;
    logic        Write_En;
    logic [2:0]  Write_Addr;
    logic [15:0] Write_Data;
    logic [7:0]  pending;
    logic        grant_id;

    int total = 0;
    int bad   = 0;

    logic [15:0] rf [8] = '{default: 16'h0000};
    logic [2:0]  lg_addr [$];
    logic [15:0] lg_data [$];
    logic        lg_gnt  [$];

    logic [2:0]  s0_addr [$];
    logic [15:0] s0_data [$];
    logic [2:0]  s1_addr [$];
    logic [15:0] s1_data [$];

    regfile_write_arbiter dut (
        .clk        (clk),
        .clr        (clr),
        .wb0_valid  (wb0_valid),
        .wb0_addr   (wb0_addr),
        .wb0_data   (wb0_data),
        .wb0_ready  (wb0_ready),
        .wb1_valid  (wb1_valid),
        .wb1_addr   (wb1_addr),
        .wb1_data   (wb1_data),
        .wb1_ready  (wb1_ready),
        .Write_En   (Write_En),
        .Write_Addr (Write_Addr),
        .Write_Data (Write_Data),
        .pending    (pending),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    // Register-file model: commits one edge after Write_En is presented.
    always @(posedge clk) begin
        if (Write_En) begin
            rf[Write_Addr] <= Write_Data;
        end
    end

    always @(negedge clk) begin
        if (Write_En) begin
            lg_addr.push_back(Write_Addr);
            lg_data.push_back(Write_Data);
            lg_gnt.push_back(grant_id);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        clr       = 1'b1;
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Drives both stream tables with valid/ready handshakes; starts and ends at a negedge.
    task automatic run_streams(input int max_cycles, output bit saw_bp1);
        int i0 = 0;
        int i1 = 0;
        bit a0, a1;
        saw_bp1 = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            if (i0 >= s0_addr.size() && i1 >= s1_addr.size()) break;
            wb0_valid = (i0 < s0_addr.size());
            if (wb0_valid) begin
                wb0_addr = s0_addr[i0];
                wb0_data = s0_data[i0];
            end
            wb1_valid = (i1 < s1_addr.size());
            if (wb1_valid) begin
                wb1_addr = s1_addr[i1];
                wb1_data = s1_data[i1];
            end
            #1;
            if (wb1_valid && !wb1_ready) saw_bp1 = 1'b1;
            a0 = wb0_valid & wb0_ready;
            a1 = wb1_valid & wb1_ready;
            @(posedge clk);
            if (a0) i0++;
            if (a1) i1++;
            @(negedge clk);
        end
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        check("stream0_accepted", i0, s0_addr.size());
        check("stream1_accepted", i1, s1_addr.size());
    endtask

    initial begin
        int          base;
        bit          bp;
        logic [2:0]  exp_a [7];
        logic [15:0] exp_d [7];
        logic        exp_g [7];
        logic [15:0] snap [8];
        int          n0, n1;

        // Reset held with toggling requesters
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            wb0_valid = c[0];
            wb0_addr  = 3'd1;
            wb1_valid = ~c[0];
            wb1_addr  = 3'd2;
            #1;
            check("rst_wen", Write_En, 0);
            check("rst_pending", pending, 0);
        end
        @(negedge clk);
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        clr = 1'b0;
        #1;
        check("rst_ready0", wb0_ready, 1);
        check("rst_ready1", wb1_ready, 1);
        check("rst_waddr", Write_Addr, 0);
        check("rst_wdata", Write_Data, 0);
        check("rst_grant", grant_id, 0);
        @(posedge clk);
        #1;
        check("rst_wen_after", Write_En, 0);
        check("rst_log_empty", lg_addr.size(), 0);

        // Single port latency
        do_reset();
        wb0_valid = 1'b1;
        wb0_addr  = 3'd3;
        wb0_data  = 16'h0012;
        @(posedge clk);
        #1;
        check("t2_wen_n", Write_En, 0);
        check("t2_pend_n", pending, 8'h08);
        @(negedge clk);
        wb0_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t2_wen_n1", Write_En, 1);
        check("t2_addr", Write_Addr, 3);
        check("t2_data", Write_Data, 16'h0012);
        check("t2_grant", grant_id, 0);
        check("t2_pend_n1", pending, 8'h08);
        @(posedge clk);
        #1;
        check("t2_wen_n2", Write_En, 0);
        check("t2_pend_n2", pending, 8'h00);
        check("t2_rf3", rf[3], 16'h0012);
        @(negedge clk);

        // Contention: alternating grants
        do_reset();
        s0_addr = '{3'd1, 3'd2, 3'd3, 3'd4};
        s0_data = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        s1_addr = '{3'd5, 3'd6, 3'd7};
        s1_data = '{16'h00A5, 16'h00A6, 16'h00A7};
        exp_a = '{3'd1, 3'd5, 3'd2, 3'd6, 3'd3, 3'd7, 3'd4};
        exp_d = '{16'h0011, 16'h00A5, 16'h0022, 16'h00A6, 16'h0033, 16'h00A7, 16'h0044};
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        base = lg_addr.size();
        run_streams(40, bp);
        repeat (6) @(negedge clk);
        check("t3_count", lg_addr.size() - base, 7);
        for (int k = 0; k < 7; k++) begin
            if (base + k < lg_addr.size()) begin
                check($sformatf("t3_addr%0d", k), lg_addr[base+k], exp_a[k]);
                check($sformatf("t3_data%0d", k), lg_data[base+k], exp_d[k]);
                check($sformatf("t3_gnt%0d", k), lg_gnt[base+k], exp_g[k]);
            end
        end

        // Backpressure on the load port
        do_reset();
        s0_addr = '{3'd1, 3'd2, 3'd3, 3'd4};
        s0_data = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        s1_addr = '{3'd5, 3'd6, 3'd7};
        s1_data = '{16'hD005, 16'hD006, 16'hD007};
        base = lg_addr.size();
        run_streams(40, bp);
        check("t4_saw_bp1", bp, 1);
        repeat (6) @(negedge clk);
        check("t4_count", lg_addr.size() - base, 7);
        n0 = 0;
        n1 = 0;
        for (int k = base; k < lg_addr.size(); k++) begin
            if (lg_gnt[k]) begin
                if (n1 < 3) begin
                    check($sformatf("t4_ld_addr%0d", n1), lg_addr[k], s1_addr[n1]);
                    check($sformatf("t4_ld_data%0d", n1), lg_data[k], s1_data[n1]);
                end
                n1++;
            end else begin
                if (n0 < 4) begin
                    check($sformatf("t4_alu_data%0d", n0), lg_data[k], s0_data[n0]);
                end
                n0++;
            end
        end
        check("t4_n_load", n1, 3);
        check("t4_n_alu", n0, 4);
        check("t4_rf7", rf[7], 16'hD007);
        check("t4_rf4", rf[4], 16'h0404);

        // Same address from both ports, rr at its reset value
        do_reset();
        wb0_valid = 1'b1;
        wb0_addr  = 3'd2;
        wb0_data  = 16'hBEEF;
        wb1_valid = 1'b1;
        wb1_addr  = 3'd2;
        wb1_data  = 16'hCAFE;
        @(posedge clk);
        #1;
        check("t5_pend_n", pending, 8'h04);
        @(negedge clk);
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t5_data1", Write_Data, 16'hBEEF);
        check("t5_grant1", grant_id, 0);
        check("t5_pend_n1", pending, 8'h04);
        @(posedge clk);
        #1;
        check("t5_data2", Write_Data, 16'hCAFE);
        check("t5_grant2", grant_id, 1);
        check("t5_pend_n2", pending, 8'h04);
        check("t5_rf2_mid", rf[2], 16'hBEEF);
        @(posedge clk);
        #1;
        check("t5_wen_end", Write_En, 0);
        check("t5_pend_end", pending, 8'h00);
        check("t5_rf2_final", rf[2], 16'hCAFE);
        @(negedge clk);

        // Asynchronous clear while queues are loaded
        do_reset();
        wb0_valid = 1'b1;
        wb0_addr  = 3'd1;
        wb0_data  = 16'h6001;
        wb1_valid = 1'b1;
        wb1_addr  = 3'd5;
        wb1_data  = 16'h6005;
        @(posedge clk);
        @(negedge clk);
        wb0_addr  = 3'd2;
        wb0_data  = 16'h6002;
        wb1_addr  = 3'd6;
        wb1_data  = 16'h6006;
        @(posedge clk);
        #1;
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        check("t6_wen_before", Write_En, 1);
        check("t6_pend_before", pending, 8'h66);
        #1;
        clr = 1'b1;
        #1;
        check("t6_wen_clr", Write_En, 0);
        check("t6_pend_clr", pending, 8'h00);
        for (int k = 0; k < 8; k++) snap[k] = rf[k];
        base = lg_addr.size();
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_no_writes", lg_addr.size() - base, 0);
        check("t6_rf1", rf[1], snap[1]);
        check("t6_rf2", rf[2], snap[2]);
        check("t6_rf5", rf[5], snap[5]);
        check("t6_rf6", rf[6], snap[6]);
        check("t6_pend_end", pending, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
